present_ti_sbox_layer: RTL
==========================

# present_ti_sbox_layer

Parametrised, pipelined 3-share threshold implementation (TI) of the PRESENT S-box layer. It processes NUM_SBOX 4-bit S-boxes in parallel per beat and adds valid/ready flow control with stall support. An optional output register stage is available. It sits between the masked key-addition and the masked pLayer in the shared PRESENT datapath, and supersedes the single-nibble, free-running shared S-box.

## Interface
- NUM_SBOX, 16: number of parallel 4-bit S-boxes; W = 4*NUM_SBOX; legal range 1..16.
- OUT_REG, 0: 0 = F stage combinational to outputs (latency 1); 1 = F outputs registered (latency 2).

- clk  in  1  single clock, all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- sbox_in1, sbox_in2, sbox_in3  in  W each  input shares 0/1/2; nibble k = bits [4k+3:4k].
- out_valid  out  1  output shares valid.
- out_ready  in  1  downstream accepts output.
- share1, share2, share3  out  W each  output shares 0/1/2.
- busy  out  1  any pipeline stage holds a valid beat.

## Operation
- Per nibble k: S = F∘G, with G and F the team's uniform, quadratic, direct-sharing 3-share component functions.
- Non-completeness: output share i of G depends only on the input shares ≠ i. Output share i of F depends only on the registered G shares ≠ i.
- Correctness: share1^share2^share3 nibble k = PRESENT_S(sbox_in1^sbox_in2^sbox_in3 nibble k).
- PRESENT_S lookup, index 0..F: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Stage 1 (mandatory) is the G-share register, 3×W bits, plus valid bit v1. This register is the glitch barrier and is never bypassed.
- Stage 2 (OUT_REG=1 only) is the F-share register, 3×W bits, plus valid bit v2.
- No fresh randomness is used. Shares are never combined inside the block.
- Flow control is an elastic pipeline. A stage loads when it is empty or its content is leaving this cycle.
  - OUT_REG=0: in_ready = !v1 | out_ready; out_valid = v1.
  - OUT_REG=1: in_ready = !v1 | (!v2 | out_ready); out_valid = v2.
- in_ready is combinational from out_ready and state only; it never depends on in_valid.
- Stalls:
  - A stalled stage holds its data registers bit-exact. Its enable is deasserted; the data is not recirculated through G/F.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - In-flight data is never dropped or duplicated.
- busy = v1 | v2 (v2 is 0 when OUT_REG=0).

## Timing
- Reset (rst_n=0, asynchronous):
  - v1 = v2 = 0 and all share registers = 0.
  - out_valid = 0, busy = 0.
  - share1..3 = F(0-shares), a constant; the bench must ignore them while out_valid=0.
  - in_ready = 1 one clock after rst_n deasserts. It is 1 combinationally in reset for OUT_REG=0.
- Reset mid-operation discards all in-flight beats immediately. No output handshake completes for them.
- Latency (in_valid&in_ready accepted on edge n):
  - OUT_REG=0: out_valid from edge n.
  - OUT_REG=1: out_valid from edge n+1.
- Throughput: one beat per clock when out_ready stays 1.
- Simultaneous accept and drain on the same edge: the stage loads the new beat and out_valid stays 1. There is no bubble.
- Full with out_ready=0: in_ready=0. Input shares may change freely without affecting held state.
- Input shares are sampled only on an accepting edge.

## Test plan
- Exhaustive nibble sweep, NUM_SBOX=1, OUT_REG=0, out_ready=1.
  - All 16 values × random share splits (≥1000 per value).
  - Required: recombined output = PRESENT_S. E.g. 0→C, 1→5, A→F, F→2; out_valid one edge after accept.
- NUM_SBOX=16, OUT_REG=1, back-to-back stream.
  - Stimulus: state 0x0123456789ABCDEF, then 0xFEDCBA9876543210, random shares.
  - Required: recombined outputs 0xC56B90AD3EF84712 then 0x21748FE3DA09B65C, on consecutive cycles, two edges after the respective accepts.
- Backpressure, OUT_REG=1.
  - Stimulus: hold out_ready=0 for 5 cycles while in_valid=1.
  - Required: exactly 2 beats accepted, then in_ready=0. Share outputs are bit-stable during the stall. Release yields both beats in order with no loss.
- Reset mid-stream.
  - Stimulus: assert rst_n=0 while v1=v2=1.
  - Required: out_valid and busy drop to 0 asynchronously, with no further output. The first beat after release has latency per OUT_REG.
- Non-completeness and uniformity check.
  - Stimulus: formal or SILVER run on NUM_SBOX=1.
  - Required: first-order probing-secure with glitches. Share i of each stage is independent of share i of its input. The G output sharing is uniform over all 4096 input share tuples.

Source files
------------

// File: rtl/present_ti_sbox_layer.sv
`default_nettype none
// ============================================================================
// Module   : present_ti_sbox_layer
// Purpose  : Three-share threshold implementation of the PRESENT S-box layer.
//            NUM_SBOX nibbles run in parallel. Each S-box is split into two
//            quadratic stages, S = F(G(x)), with a register between them. An
//            elastic valid/ready pipeline lets the block stall without losing
//            beats.
// Ports    : clk, rst_n                 clock, async active-low reset
//            in_valid / in_ready        input handshake
//            sbox_in1..3 [W-1:0]        input shares, nibble k = [4k+3:4k]
//            out_valid / out_ready      output handshake
//            share1..3 [W-1:0]          output shares
//            busy                       some stage holds a valid beat
// Params   : NUM_SBOX (1..16)           parallel S-boxes, W = 4*NUM_SBOX
//            OUT_REG  (0/1)             register the F shares (latency 2)
// Revision : 1.0 - initial release
// ============================================================================
module present_ti_sbox_layer #(
    parameter int NUM_SBOX = 16,
    parameter int OUT_REG  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NUM_SBOX-1:0] sbox_in1,
    input  logic [4*NUM_SBOX-1:0] sbox_in2,
    input  logic [4*NUM_SBOX-1:0] sbox_in3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NUM_SBOX-1:0] share1,
    output logic [4*NUM_SBOX-1:0] share2,
    output logic [4*NUM_SBOX-1:0] share3,
    output logic                  busy
);

    localparam int W = 4 * NUM_SBOX;

    // Direct sharing of the product x_i*x_j for one output share, built only
    // from the two input shares p and q that this output share may see.
    function automatic logic qterm(input logic [3:0] p, input logic [3:0] q,
                                   input int i, input int j);
        return (p[i] & p[j]) ^ (p[i] & q[j]) ^ (q[i] & p[j]);
    endfunction

    // G component:  g0 = 1^x0^x1x2^x1x3^x2x3, g1 = 1^x1^x3^x0x1^x0x2,
    //               g2 = 1^x1^x2,             g3 = x0^x1^x2.
    // The constant is injected into exactly one share (c=1).
    function automatic logic [3:0] g_comp(input logic [3:0] p, input logic [3:0] q,
                                          input logic c);
        logic [3:0] g;
        g[0] = c ^ p[0] ^ qterm(p, q, 1, 2) ^ qterm(p, q, 1, 3) ^ qterm(p, q, 2, 3);
        g[1] = c ^ p[1] ^ p[3] ^ qterm(p, q, 0, 1) ^ qterm(p, q, 0, 2);
        g[2] = c ^ p[1] ^ p[2];
        g[3] = p[0] ^ p[1] ^ p[2];
        return g;
    endfunction

    // F component:  f0 = x1^x0x2, f1 = x1^x2^x0x3, f2 = x3^x0x1,
    //               f3 = x0^x1^x2^x0x3.
    function automatic logic [3:0] f_comp(input logic [3:0] p, input logic [3:0] q);
        logic [3:0] f;
        f[0] = p[1] ^ qterm(p, q, 0, 2);
        f[1] = p[1] ^ p[2] ^ qterm(p, q, 0, 3);
        f[2] = p[3] ^ qterm(p, q, 0, 1);
        f[3] = p[0] ^ p[1] ^ p[2] ^ qterm(p, q, 0, 3);
        return f;
    endfunction

    logic [W-1:0] g1_d, g2_d, g3_d;
    logic [W-1:0] g1_q, g2_q, g3_q;
    logic [W-1:0] f1, f2, f3;
    logic         v1_q;
    logic         ld1;

    // Output share i of each stage never sees input share i.
    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
        assign g1_d[4*k +: 4] = g_comp(sbox_in2[4*k +: 4], sbox_in3[4*k +: 4], 1'b1);
        assign g2_d[4*k +: 4] = g_comp(sbox_in3[4*k +: 4], sbox_in1[4*k +: 4], 1'b0);
        assign g3_d[4*k +: 4] = g_comp(sbox_in1[4*k +: 4], sbox_in2[4*k +: 4], 1'b0);
        assign f1[4*k +: 4]   = f_comp(g2_q[4*k +: 4], g3_q[4*k +: 4]);
        assign f2[4*k +: 4]   = f_comp(g3_q[4*k +: 4], g1_q[4*k +: 4]);
        assign f3[4*k +: 4]   = f_comp(g1_q[4*k +: 4], g2_q[4*k +: 4]);
    end

    // G-share register: the glitch barrier between the two quadratic layers.
    // Data is enabled only on an accepting edge, so a stall holds it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            g1_q <= '0;
            g2_q <= '0;
            g3_q <= '0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid;
            end
            if (ld1 && in_valid) begin
                g1_q <= g1_d;
                g2_q <= g2_d;
                g3_q <= g3_d;
            end
        end
    end

    assign in_ready = ld1;

    if (OUT_REG != 0) begin : g_out_reg
        logic         v2_q;
        logic         ld2;
        logic [W-1:0] s1_q, s2_q, s3_q;

        // A stage may load when empty or when its content leaves this cycle.
        assign ld2 = !v2_q | out_ready;
        assign ld1 = !v1_q | ld2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_q <= 1'b0;
                s1_q <= '0;
                s2_q <= '0;
                s3_q <= '0;
            end else begin
                if (ld2) begin
                    v2_q <= v1_q;
                end
                if (ld2 && v1_q) begin
                    s1_q <= f1;
                    s2_q <= f2;
                    s3_q <= f3;
                end
            end
        end

        assign out_valid = v2_q;
        assign share1    = s1_q;
        assign share2    = s2_q;
        assign share3    = s3_q;
        assign busy      = v1_q | v2_q;
    end else begin : g_comb_out
        assign ld1       = !v1_q | out_ready;
        assign out_valid = v1_q;
        assign share1    = f1;
        assign share2    = f2;
        assign share3    = f3;
        assign busy      = v1_q;
    end

endmodule
`default_nettype wire
